// File: rtl/hough_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hough_pkg
// Purpose  : Shared constants and the state encoding for the Hough vote
//            accumulator and its vote RAM.
// Revision : 1.0  initial release
// ============================================================================
package hough_pkg;

  // Default geometry. Rho arrives already offset by MAX_RHO, so it is unsigned.
  localparam int RHO_BINS   = 1600;
  localparam int THETA_BINS = 181;
  localparam int MAX_RHO    = 800;

  // Default widths.
  localparam int RHO_W      = 11;
  localparam int THETA_W    = 8;
  localparam int VOTE_W     = 10;
  localparam int ADDR_W     = 19;

  // One-hot, matching the upstream Hough control FSM.
  typedef enum logic [5:0] {
    ST_IDLE  = 6'b000001,
    ST_CLEAR = 6'b000010,
    ST_ACCUM = 6'b000100,
    ST_DRAIN = 6'b001000,
    ST_SCAN  = 6'b010000,
    ST_DONE  = 6'b100000
  } state_t;

endpackage
`default_nettype wire

// File: rtl/hough_vote_ram.sv
`default_nettype none
// ============================================================================
// Module   : hough_vote_ram
// Purpose  : Simple dual-port vote RAM, one write port and one synchronous
//            read port. Read latency is one cycle; on a same-address
//            read/write collision the read returns the old contents.
// Ports    : clock        rising-edge clock
//            we           write enable
//            waddr/wdata  write address / data
//            raddr        read address
//            rdata        registered read data (one cycle after raddr)
// Revision : 1.0  initial release
// ============================================================================
module hough_vote_ram #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 10
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  import hough_pkg::*;

  logic [DATA_W-1:0] mem [DEPTH];

  // Both updates are non-blocking, so a colliding read sees the old word.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/hough_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : hough_accumulator
// Purpose  : Hough vote accumulator and peak finder. Clears the vote RAM on
//            start, increments one (rho, theta) bin per accepted vote through
//            a forwarded read-modify-write pipeline, then scans every bin on
//            frame completion and reports the strongest line.
// Ports    : clock, reset          clock / synchronous active-high reset
//            start                 begin a frame (honoured in IDLE only)
//            vote_valid            one vote this cycle
//            rho_index/theta_index vote bin
//            frame_done            end of votes for the frame
//            busy                  high in CLEAR, DRAIN and SCAN
//            accepting             high in ACCUM
//            peak_valid            one-cycle pulse, peak_* are final
//            peak_rho/theta/votes  strongest bin
//            dropped_votes         saturating count of out-of-range votes
// Revision : 1.0  initial release
// ============================================================================
module hough_accumulator #(
  parameter int RHO_BINS   = hough_pkg::RHO_BINS,
  parameter int THETA_BINS = hough_pkg::THETA_BINS,
  parameter int VOTE_W     = hough_pkg::VOTE_W,
  parameter int RHO_W      = hough_pkg::RHO_W,
  parameter int THETA_W    = hough_pkg::THETA_W,
  parameter int ADDR_W     = hough_pkg::ADDR_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               vote_valid,
  input  logic [RHO_W-1:0]   rho_index,
  input  logic [THETA_W-1:0] theta_index,
  input  logic               frame_done,
  output logic               busy,
  output logic               accepting,
  output logic               peak_valid,
  output logic [RHO_W-1:0]   peak_rho,
  output logic [THETA_W-1:0] peak_theta,
  output logic [VOTE_W-1:0]  peak_votes,
  output logic [15:0]        dropped_votes
);
  import hough_pkg::*;

  localparam int                 N         = RHO_BINS * THETA_BINS;
  // One extra bit so the scan counter can reach N itself.
  localparam logic [ADDR_W:0]    N_CNT     = (ADDR_W+1)'(N);
  localparam logic [ADDR_W:0]    LAST_CNT  = (ADDR_W+1)'(N - 1);
  localparam logic [ADDR_W:0]    DRAIN_END = (ADDR_W+1)'(1);
  localparam logic [RHO_W:0]     RHO_LIM   = (RHO_W+1)'(RHO_BINS);
  localparam logic [THETA_W:0]   THETA_LIM = (THETA_W+1)'(THETA_BINS);
  localparam logic [RHO_W-1:0]   RHO_LAST  = RHO_W'(RHO_BINS - 1);
  localparam logic [VOTE_W-1:0]  VOTE_MAX  = '1;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W:0]     r_cnt;

  // S0: vote qualification and address
  logic                w_in_range;
  logic                w_s0_valid;
  logic                w_drop;
  logic [ADDR_W-1:0]   w_s0_addr;

  // S1: read data arrives, increment and write back
  logic                r_s1_valid;
  logic [ADDR_W-1:0]   r_s1_addr;
  logic                r_fwd;
  logic [VOTE_W-1:0]   r_fwd_data;
  logic [VOTE_W-1:0]   w_base;
  logic [VOTE_W-1:0]   w_inc;

  // RAM ports
  logic                w_we;
  logic [ADDR_W-1:0]   w_waddr;
  logic [VOTE_W-1:0]   w_wdata;
  logic [ADDR_W-1:0]   w_raddr;
  logic [VOTE_W-1:0]   w_rdata;

  // Scan position, and the same position delayed to line up with read data
  logic [RHO_W-1:0]    r_scan_rho;
  logic [THETA_W-1:0]  r_scan_theta;
  logic                r_cmp_valid;
  logic [RHO_W-1:0]    r_cmp_rho;
  logic [THETA_W-1:0]  r_cmp_theta;

  // --------------------------------------------------------------------------
  // Vote qualification
  // --------------------------------------------------------------------------
  assign w_in_range = ({1'b0, rho_index} < RHO_LIM) && ({1'b0, theta_index} < THETA_LIM);
  assign w_s0_valid = (r_state == ST_ACCUM) && vote_valid && w_in_range;
  assign w_drop     = (r_state == ST_ACCUM) && vote_valid && !w_in_range;
  assign w_s0_addr  = ADDR_W'(theta_index) * ADDR_W'(RHO_BINS) + ADDR_W'(rho_index);

  // The RAM cannot return a word written in the very same cycle, so a vote
  // that hits the bin S1 is writing picks up the value captured in r_fwd_data.
  assign w_base = r_fwd ? r_fwd_data : w_rdata;
  assign w_inc  = (w_base == VOTE_MAX) ? VOTE_MAX : w_base + 1'b1;

  // --------------------------------------------------------------------------
  // RAM port muxing
  // --------------------------------------------------------------------------
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_s1_addr;
    w_wdata = w_inc;
    w_raddr = '0;
    if (r_state == ST_CLEAR) begin
      w_we    = 1'b1;
      w_waddr = r_cnt[ADDR_W-1:0];
      w_wdata = '0;
    end else if (r_s1_valid) begin
      w_we    = 1'b1;
    end
    // A reset in the same cycle discards the pending write.
    if (reset) begin
      w_we = 1'b0;
    end
    if (r_state == ST_SCAN) begin
      if (r_cnt < N_CNT) begin
        w_raddr = r_cnt[ADDR_W-1:0];
      end
    end else if (w_s0_valid) begin
      w_raddr = w_s0_addr;
    end
  end

  hough_vote_ram #(
    .DEPTH  (N),
    .ADDR_W (ADDR_W),
    .DATA_W (VOTE_W)
  ) u_ram (
    .clock (clock),
    .we    (w_we),
    .waddr (w_waddr),
    .wdata (w_wdata),
    .raddr (w_raddr),
    .rdata (w_rdata)
  );

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      // Every timed state starts counting from zero on entry.
      r_cnt   <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next     = r_state;
    busy       = 1'b0;
    accepting  = 1'b0;
    peak_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_CLEAR;
      end
      ST_CLEAR: begin
        busy = 1'b1;
        if (r_cnt == LAST_CNT) w_next = ST_ACCUM;
      end
      ST_ACCUM: begin
        accepting = 1'b1;
        if (frame_done) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (r_cnt == DRAIN_END) w_next = ST_SCAN;
      end
      ST_SCAN: begin
        busy = 1'b1;
        // N reads plus one cycle for the last read to return.
        if (r_cnt == N_CNT) w_next = ST_DONE;
      end
      ST_DONE: begin
        peak_valid = 1'b1;
        w_next     = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // RMW pipeline, drop counter and peak tracking
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_valid    <= 1'b0;
      r_s1_addr     <= '0;
      r_fwd         <= 1'b0;
      r_fwd_data    <= '0;
      r_scan_rho    <= '0;
      r_scan_theta  <= '0;
      r_cmp_valid   <= 1'b0;
      r_cmp_rho     <= '0;
      r_cmp_theta   <= '0;
      peak_rho      <= '0;
      peak_theta    <= '0;
      peak_votes    <= '0;
      dropped_votes <= '0;
    end else begin
      r_s1_valid <= w_s0_valid;
      r_s1_addr  <= w_s0_addr;
      r_fwd      <= w_s0_valid && r_s1_valid && (w_s0_addr == r_s1_addr);
      r_fwd_data <= w_inc;

      if ((r_state == ST_IDLE) && start) begin
        dropped_votes <= '0;
      end else if (w_drop && (dropped_votes != 16'hFFFF)) begin
        dropped_votes <= dropped_votes + 16'd1;
      end

      // Rho/theta walk in address order alongside the scan counter.
      if (r_state != ST_SCAN) begin
        r_scan_rho   <= '0;
        r_scan_theta <= '0;
      end else if (r_scan_rho == RHO_LAST) begin
        r_scan_rho   <= '0;
        r_scan_theta <= r_scan_theta + 1'b1;
      end else begin
        r_scan_rho   <= r_scan_rho + 1'b1;
      end
      r_cmp_valid <= (r_state == ST_SCAN) && (r_cnt < N_CNT);
      r_cmp_rho   <= r_scan_rho;
      r_cmp_theta <= r_scan_theta;

      // The peak outputs are the running maximum; strict greater-than keeps
      // the lowest address on a tie.
      if ((r_state == ST_IDLE) && start) begin
        peak_rho   <= '0;
        peak_theta <= '0;
        peak_votes <= '0;
      end else if (r_cmp_valid && (w_rdata > peak_votes)) begin
        peak_rho   <= r_cmp_rho;
        peak_theta <= r_cmp_theta;
        peak_votes <= w_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hough_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_hough_accumulator
// Purpose  : Self-checking bench for hough_accumulator with a 16 x 4 bin
//            accumulator and 3-bit vote counters. A bin-level model predicts
//            each frame's peak; expectations are queued at frame_done and
//            compared when peak_valid arrives.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hough_accumulator;

  localparam int RB = 16;
  localparam int TB = 4;
  localparam int VW = 3;
  localparam int NB = RB * TB;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        vote_valid = 1'b0;
  logic        frame_done = 1'b0;
  logic [10:0] rho_index = '0;
  logic [7:0]  theta_index = '0;
  logic        busy;
  logic        accepting;
  logic        peak_valid;
  logic [10:0] peak_rho;
  logic [7:0]  peak_theta;
  logic [2:0]  peak_votes;
  logic [15:0] dropped_votes;

  always #5 clock = ~clock;

  hough_accumulator #(
    .RHO_BINS   (RB),
    .THETA_BINS (TB),
    .VOTE_W     (VW),
    .RHO_W      (11),
    .THETA_W    (8),
    .ADDR_W     (6)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .vote_valid    (vote_valid),
    .rho_index     (rho_index),
    .theta_index   (theta_index),
    .frame_done    (frame_done),
    .busy          (busy),
    .accepting     (accepting),
    .peak_valid    (peak_valid),
    .peak_rho      (peak_rho),
    .peak_theta    (peak_theta),
    .peak_votes    (peak_votes),
    .dropped_votes (dropped_votes)
  );

  typedef struct {
    int rho;
    int theta;
    int votes;
    int dropped;
  } exp_t;

  exp_t sb[$];
  int   model[NB];
  int   drop_m;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_vote(input int r, input int t);
    if (r >= RB || t >= TB) begin
      if (drop_m < 65535) drop_m++;
    end else if (model[t*RB + r] < (1 << VW) - 1) begin
      model[t*RB + r]++;
    end
  endtask

  task automatic vote(input int r, input int t);
    rho_index   = 11'(r);
    theta_index = 8'(t);
    vote_valid  = 1'b1;
    model_vote(r, t);
    tick();
    vote_valid  = 1'b0;
  endtask

  task automatic push_expected();
    exp_t e;
    e = '{0, 0, 0, drop_m};
    for (int a = 0; a < NB; a++) begin
      if (model[a] > e.votes) begin
        e.votes = model[a];
        e.rho   = a % RB;
        e.theta = a / RB;
      end
    end
    sb.push_back(e);
  endtask

  task automatic begin_frame();
    int cnt;
    cnt = 0;
    foreach (model[i]) model[i] = 0;
    drop_m = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!accepting && cnt < 200) begin
      tick();
      cnt++;
    end
    check("clear_cycles", cnt, NB);
  endtask

  task automatic end_frame(input bit with_vote, input int r, input int t);
    int   cnt;
    exp_t e;
    cnt = 1;
    if (with_vote) begin
      rho_index   = 11'(r);
      theta_index = 8'(t);
      vote_valid  = 1'b1;
      model_vote(r, t);
    end
    frame_done = 1'b1;
    push_expected();
    tick();
    frame_done = 1'b0;
    vote_valid = 1'b0;
    while (!peak_valid && cnt < 300) begin
      tick();
      cnt++;
    end
    check("peak_latency", cnt, NB + 4);
    e = sb.pop_front();
    check("peak_rho", peak_rho, e.rho);
    check("peak_theta", peak_theta, e.theta);
    check("peak_votes", peak_votes, e.votes);
    check("dropped_votes", dropped_votes, e.dropped);
    check("busy_in_done", busy, 0);
    tick();
    check("peak_pulse_width", peak_valid, 0);
    check("peak_hold", peak_votes, e.votes);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_busy", busy, 0);
    check("rst_accepting", accepting, 0);
    check("rst_peak_valid", peak_valid, 0);
    check("rst_peak_rho", peak_rho, 0);
    check("rst_peak_theta", peak_theta, 0);
    check("rst_peak_votes", peak_votes, 0);
    check("rst_dropped", dropped_votes, 0);

    // Empty frame: every bin cleared, peak is all zeros.
    begin_frame();
    end_frame(0, 0, 0);

    // Back-to-back votes to one bin exercise forwarding.
    begin_frame();
    repeat (5) vote(7, 2);
    end_frame(0, 0, 0);

    // Votes and frame_done outside ACCUM are ignored.
    rho_index = 11'd20; theta_index = 8'd0; vote_valid = 1'b1; frame_done = 1'b1;
    tick();
    vote_valid = 1'b0; frame_done = 1'b0;
    check("idle_vote_ignored", dropped_votes, 0);
    check("idle_stays_idle", busy, 0);

    // Tie: the lower address wins.
    begin_frame();
    repeat (3) vote(3, 1);
    repeat (3) vote(9, 0);
    end_frame(0, 0, 0);

    // Saturation, drops, and a start pulse during ACCUM that must be ignored.
    begin_frame();
    repeat (5) vote(4, 3);
    start = 1'b1;
    vote(4, 3);
    start = 1'b0;
    check("start_ignored_in_accum", accepting, 1);
    repeat (4) vote(4, 3);
    vote(16, 0);
    vote(0, 4);
    end_frame(0, 0, 0);

    // Only rejected votes: nothing may land in the RAM.
    begin_frame();
    vote(16, 1);
    vote(5, 4);
    end_frame(0, 0, 0);

    // Vote coincident with frame_done still counts.
    begin_frame();
    vote(1, 1);
    vote(1, 1);
    end_frame(1, 1, 1);

    // Alternating bins plus a pseudo-random mix including out-of-range votes.
    begin_frame();
    vote(2, 3); vote(5, 1); vote(2, 3); vote(2, 3);
    for (int i = 0; i < 40; i++) begin
      vote(int'($urandom_range(0, RB + 1)), int'($urandom_range(0, TB)));
    end
    end_frame(0, 0, 0);

    // Reset while scanning.
    begin_frame();
    repeat (4) vote(6, 0);
    vote(16, 0);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    repeat (14) tick();
    check("mid_scan_busy", busy, 1);
    check("mid_scan_partial_peak", peak_votes, 4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("post_rst_busy", busy, 0);
    check("post_rst_peak_valid", peak_valid, 0);
    check("post_rst_peak_rho", peak_rho, 0);
    check("post_rst_peak_theta", peak_theta, 0);
    check("post_rst_peak_votes", peak_votes, 0);
    check("post_rst_dropped", dropped_votes, 0);
    tick();
    check("post_rst_idle", busy | accepting | peak_valid, 0);

    // A fresh frame must not see the interrupted frame's votes.
    begin_frame();
    end_frame(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hough_accumulator.md
# hough_accumulator

Vote accumulator and peak finder for the Hough line-detection pipeline. It sits directly downstream of the Hough control FSM. Each cycle that FSM asserts its write enable, the block consumes one (rho index, theta index) vote and increments the matching bin of an on-chip vote RAM. When the FSM reports frame completion, the block scans the whole accumulator and reports the strongest line as (rho, theta, votes).

## Interface
Parameters:
- RHO_BINS, 1600: rho bins; upstream offset by max_rho = 800, so the index range is 0..1599.
- THETA_BINS, 181: theta bins, 0..180 degrees.
- VOTE_W, 10: vote counter width; counters saturate.
- RHO_W, 11: rho index width.
- THETA_W, 8: theta index width.
- ADDR_W, 19: vote RAM address width; must satisfy ceil(log2(RHO_BINS*THETA_BINS)) <= ADDR_W.

Ports (one clock; reset is synchronous and active-high; ports named clock and reset):
- clock, in, 1: sole clock; all logic on its rising edge.
- reset, in, 1: synchronous, active-high.
- start, in, 1: one-cycle pulse that begins a frame (clear, then accumulate).
- vote_valid, in, 1: one vote this cycle (upstream write_enable).
- rho_index, in, RHO_W: rho bin, already offset.
- theta_index, in, THETA_W: theta bin.
- frame_done, in, 1: pulse marking the end of votes for the frame (upstream ready).
- busy, out, 1: high in CLEAR, DRAIN and SCAN.
- accepting, out, 1: high in ACCUM only.
- peak_valid, out, 1: one-cycle pulse when the peak result is ready.
- peak_rho, out, RHO_W: rho of the maximum bin.
- peak_theta, out, THETA_W: theta of the maximum bin.
- peak_votes, out, VOTE_W: vote count of the maximum bin.
- dropped_votes, out, 16: saturating count of rejected votes for the frame.

## Operation
- Reset values: state IDLE; busy, accepting, peak_valid = 0; peak_rho, peak_theta, peak_votes, dropped_votes = 0. RAM contents are undefined after reset until the next CLEAR.
- Address = theta_index*RHO_BINS + rho_index, computed at ADDR_W width with no truncation.
- States:
  - IDLE: start -> CLEAR. Clears dropped_votes and peak_* outputs.
  - CLEAR: writes 0 to addresses 0..N-1, where N = RHO_BINS*THETA_BINS. After the last write -> ACCUM.
  - ACCUM: accepts one vote per cycle. frame_done -> DRAIN.
  - DRAIN: 2 cycles so the RMW pipeline empties -> SCAN.
  - SCAN: reads 0..N-1 in order, tracking the running maximum -> DONE.
  - DONE: peak_valid = 1 for one cycle -> IDLE.
- Vote rejection: a vote with rho_index >= RHO_BINS or theta_index >= THETA_BINS is not written and increments dropped_votes. dropped_votes saturates at 0xFFFF.
- Votes outside ACCUM: vote_valid is ignored and not counted.
- Start ignored: start is ignored in every state except IDLE.
- Read-modify-write pipeline:
  - S0 issues the RAM read.
  - S1 gets read data, computes min(data+1, 2^VOTE_W-1) and writes it back.
  - Forwarding: if the S0 address equals the address being written in S1, S0 uses the written value instead of the stale RAM data. Consecutive votes to the same bin must each count.
- Peak selection: strict greater-than against the running maximum, so on a tie the lowest address wins. If every bin is 0, the peak is rho = 0, theta = 0, votes = 0.
- Peak outputs hold their value until the next start.

## Timing
- Throughput: 1 vote/cycle in ACCUM, with no backpressure.
- Latency: RAM write 2 cycles after vote_valid is sampled.
- Durations: CLEAR takes N cycles, DRAIN 2, and SCAN N+1 (1-cycle RAM read latency).
- Result timing: peak_valid asserts N+4 cycles after frame_done is sampled. That is 2 DRAIN cycles, then N+1 SCAN cycles, then the first DONE cycle.
- frame_done with vote_valid in the same cycle: the vote is accepted, then the state moves to DRAIN.
- frame_done outside ACCUM is ignored.
- reset mid-operation: return to IDLE next cycle with all outputs at reset values. Any pending RAM write is discarded.

## Structure
- Package hough_pkg holds:
  - RHO_BINS, THETA_BINS, MAX_RHO (800);
  - widths RHO_W, THETA_W, VOTE_W, ADDR_W;
  - the state encoding (one-hot, matching the upstream FSM style).
- Sub-module hough_vote_ram: simple dual-port (1 write, 1 synchronous read) RAM of N x VOTE_W, with 1-cycle read latency and read-old-data on an address collision. All forwarding is done in hough_accumulator.

## Test plan
The bench overrides RHO_BINS = 16 and THETA_BINS = 4 (N = 64).
- Clear: start, wait 64 cycles, then frame_done -> SCAN sees all zeros; peak_valid with rho 0, theta 0, votes 0.
- Back-to-back same bin: 5 consecutive votes (rho 7, theta 2) -> peak_rho 7, peak_theta 2, peak_votes 5. Checks forwarding.
- Tie: 3 votes each to (rho 3, theta 1) and (rho 9, theta 0) -> peak rho 9, theta 0 (address 9 < 19).
- Saturation and drops: with VOTE_W = 3, 10 votes to (rho 4, theta 3) -> votes 7. Votes with rho 16 and theta 4 -> dropped_votes 2, and no RAM change.
- Simultaneous events: vote and frame_done in the same cycle -> the vote is counted; peak_valid exactly 64+4 cycles after frame_done.
- Mid-scan reset: reset during SCAN -> all outputs 0 next cycle, then IDLE. A fresh start re-clears and the prior frame's votes are absent.
